beat_tone_gen: RTL and testbench
================================

Name: beat_tone_gen

Overview:
Downstream consumer of the beat-index counter. It takes the 8-bit beat index, looks up the note for that beat in a small writable score memory, and drives a square-wave audio output at that note's pitch. Sequencing stays in the upstream counter; this block only turns beats into sound.

Parameters:
BEATLENGTH, 4, number of score entries (beats 0..BEATLENGTH-1); an index >= BEATLENGTH means idle/stopped.
DIV_W, 18, width of the half-period counter and half-period values.
DIV_SHIFT, 0, right shift applied to every half-period (simulation speed-up); the result is clamped to a minimum of 1.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
ibeat  in  8  beat index from the beat counter.
wr_en  in  1  score write strobe.
wr_addr  in  8  score write address.
wr_note  in  5  note code to write.
mute  in  1  forces audio silent; does not stop the tone counter.
audio_out  out  1  square-wave audio.
note_cur  out  5  note code currently sounding (0 = rest).
note_valid  out  1  high while a non-rest note sounds and mute=0.
beat_tick  out  1  one-cycle pulse when a new beat is latched.

Behaviour:
- Reset (sync, rst=1 at an edge): all score entries <= 0 (rest); ibeat_q <= BEATLENGTH; note_cur, cnt, audio_out, beat_tick, note_valid <= 0. rst has priority over every other input, including wr_en.
- Score memory: BEATLENGTH x 5 bits, combinational read.
  - Write at an edge when wr_en=1 and wr_addr < BEATLENGTH; writes with wr_addr >= BEATLENGTH are ignored.
  - A read in the same cycle as a write to the same address returns the old value.
- Note codes:
  - 0 = rest; codes 25..31 are also treated as rest.
  - 1..12 = C4..B4. Normative half-periods (100 MHz): 191113, 180387, 170262, 160706, 151686, 143173, 135137, 127553, 120394, 113636, 107259, 101239.
  - 13..24 = C5..B5: half-period is the matching octave-4 value >> 1.
  - Final half-period hp = max(1, value >> DIV_SHIFT), truncated to DIV_W bits.
- Beat change detection: ibeat_q holds the last latched index; beat_chg = (ibeat != ibeat_q).
  - At an edge with beat_chg=1: ibeat_q <= ibeat; beat_tick <= 1; cnt <= 0; audio_out <= 0 (phase restart / articulation).
  - Same edge: note_cur <= score[ibeat] if ibeat < BEATLENGTH and the code is 1..24, else 0.
  - Latency: ibeat change to note_cur/beat_tick update is 1 clock.
  - No change: beat_tick <= 0 and note_cur holds. A write to the currently playing beat does not alter note_cur until the next beat change.
- Retriggering the same beat: upstream looping BEATLENGTH-1 -> 0 -> ... always changes the index, so every beat retriggers, even when consecutive notes are equal.
- Tone counter (note_cur != 0): cnt increments each clock.
  - When cnt == hp-1: cnt <= 0 and the internal phase toggles.
  - Square period = 2*hp clocks; the first toggle (phase 0 -> 1) occurs hp clocks after the retrigger edge.
- Rest (note_cur == 0): cnt and phase are held at 0.
- Output gating: audio_out = phase AND NOT mute, registered, so mute takes effect at the next edge.
- note_valid = (note_cur != 0) AND NOT mute, registered the same way.
- ibeat >= BEATLENGTH (includes the upstream reset value): silent. A change from one idle value to another still pulses beat_tick, and note_cur = 0.

Test Plan:
- Reset: rst=1 for 2 cycles, then ibeat=4 (BEATLENGTH=4) -> audio_out=0, note_cur=0, beat_tick never pulses, and all score entries read 0.
- Basic tone (DIV_SHIFT=10): write score[0]=10 (A4, hp=110); step ibeat 4 -> 0 -> one cycle later note_cur=10 and beat_tick=1 for exactly 1 cycle; audio_out rises 110 clocks after the retrigger edge and has period 220.
- Octave and sequence: score = {10, 22, 0, 1}; ibeat steps 0,1,2,3 every 2000 cycles -> periods 220, 110 (A5 hp=55), silence with note_valid=0, then 2*186 (C4 191113>>10).
- Out-of-range write and boundary: wr_en with wr_addr=4 and wr_note=5 -> no entry changes; ibeat=7 -> note_cur=0. A write to the playing beat changes note_cur only after the next beat change.
- Mute: during an A4 tone, mute=1 -> audio_out=0 and note_valid=0 from the next edge while cnt keeps counting; mute=0 -> output resumes in phase with the uninterrupted square wave.
- Reset mid-note: rst=1 while playing -> the next edge gives audio_out=0 and note_cur=0, and the score is cleared; after release, ibeat=0 produces a rest.

Source files
------------

// File: rtl/beat_tone_gen.sv
// beat_tone_gen: maps beat indices through a writable score to a square-wave note output
module beat_tone_gen #(
  parameter int BEATLENGTH = 4,
  parameter int DIV_W      = 18,
  parameter int DIV_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ibeat,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [4:0] wr_note,
  input  logic       mute,
  output logic       audio_out,
  output logic [4:0] note_cur,
  output logic       note_valid,
  output logic       beat_tick
);
  localparam int AW = BEATLENGTH > 1 ? $clog2(BEATLENGTH) : 1;
  localparam logic [7:0] BL = 8'(BEATLENGTH);
  localparam logic [17:0] HP4 [12] = '{18'd191113, 18'd180387, 18'd170262, 18'd160706,
                                       18'd151686, 18'd143173, 18'd135137, 18'd127553,
                                       18'd120394, 18'd113636, 18'd107259, 18'd101239};
  logic [4:0] score [BEATLENGTH];
  logic [7:0] ibeat_q;
  logic [DIV_W-1:0] cnt, cnt_n, hp;
  logic [4:0] rd, note_n;
  logic [3:0] i4;
  logic [17:0] hv;
  logic [31:0] sh;
  logic beat_chg, wrap, phase, phase_n;
  always_comb begin
    beat_chg = ibeat != ibeat_q;
    rd = ibeat < BL ? score[ibeat[AW-1:0]] : 5'd0;
    note_n = beat_chg ? ((rd >= 5'd1 && rd <= 5'd24) ? rd : 5'd0) : note_cur;
    i4 = note_cur == 5'd0 ? 4'd0 : note_cur > 5'd12 ? 4'(note_cur - 5'd13) : 4'(note_cur - 5'd1);
    // octave 5 is exactly half the octave-4 half-period
    hv = note_cur > 5'd12 ? {1'b0, HP4[i4][17:1]} : HP4[i4];
    sh = 32'(hv) >> DIV_SHIFT;
    hp = sh == 32'd0 ? DIV_W'(1) : sh[DIV_W-1:0];
    wrap = cnt == hp - 1'b1;
    cnt_n = (beat_chg || note_cur == 5'd0 || wrap) ? '0 : cnt + 1'b1;
    phase_n = (beat_chg || note_cur == 5'd0) ? 1'b0 : phase ^ wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      score      <= '{default: '0};
      ibeat_q    <= BL;
      note_cur   <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      audio_out  <= 1'b0;
      beat_tick  <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      if (wr_en && wr_addr < BL) score[wr_addr[AW-1:0]] <= wr_note;
      ibeat_q    <= ibeat;
      beat_tick  <= beat_chg;
      note_cur   <= note_n;
      cnt        <= cnt_n;
      phase      <= phase_n;
      audio_out  <= phase_n & ~mute;
      note_valid <= (note_n != 5'd0) & ~mute;
    end
  end
endmodule

// File: tb/tb_beat_tone_gen.sv
// tb_beat_tone_gen: table-driven and sequence checks of beat_tone_gen with DIV_SHIFT=10
module tb_beat_tone_gen;
  logic clk = 1'b0, rst, wr_en, mute, audio_out, note_valid, beat_tick;
  logic [7:0] ibeat, wr_addr;
  logic [4:0] wr_note, note_cur;
  int total = 0, bad = 0;

  beat_tone_gen #(.BEATLENGTH(4), .DIV_W(18), .DIV_SHIFT(10)) dut (
    .clk(clk), .rst(rst), .ibeat(ibeat), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .mute(mute), .audio_out(audio_out), .note_cur(note_cur),
    .note_valid(note_valid), .beat_tick(beat_tick));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ib;
    logic       we;
    logic [7:0] wa;
    logic [4:0] wn;
    logic       mu;
    logic [4:0] en;
    logic       et;
    logic       ev;
  } vec_t;
  vec_t v[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (audio_out !== lvl && n < 5000);
  endtask

  initial begin
    int n, e, highs, errs, exp;
    int hps[4];
    hps = '{110, 55, 0, 186};
    rst = 1; ibeat = 8'd4; wr_en = 0; wr_addr = 0; wr_note = 0; mute = 0;
    tick(); tick();
    chk("rst_audio", audio_out, 0);
    chk("rst_note", note_cur, 0);
    chk("rst_tick", beat_tick, 0);
    chk("rst_valid", note_valid, 0);
    rst = 0;
    highs = 0;
    repeat (5) begin tick(); highs += int'(beat_tick); end
    chk("idle_no_tick", highs, 0);

    v[0]  = '{8'd0, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[1]  = '{8'd1, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[2]  = '{8'd2, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[3]  = '{8'd3, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[4]  = '{8'd3, 1'b1, 8'd3, 5'd1,  1'b0, 5'd0,  1'b0, 1'b0};
    v[5]  = '{8'd4, 1'b1, 8'd0, 5'd10, 1'b0, 5'd0,  1'b1, 1'b0};
    v[6]  = '{8'd7, 1'b1, 8'd4, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0};
    v[7]  = '{8'd7, 1'b1, 8'd1, 5'd22, 1'b0, 5'd0,  1'b0, 1'b0};
    v[8]  = '{8'd0, 1'b0, 8'd0, 5'd0,  1'b0, 5'd10, 1'b1, 1'b1};
    v[9]  = '{8'd0, 1'b1, 8'd0, 5'd1,  1'b0, 5'd10, 1'b0, 1'b1};
    v[10] = '{8'd1, 1'b1, 8'd0, 5'd10, 1'b0, 5'd22, 1'b1, 1'b1};
    v[11] = '{8'd2, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[12] = '{8'd0, 1'b0, 8'd0, 5'd0,  1'b1, 5'd10, 1'b1, 1'b0};
    v[13] = '{8'd3, 1'b0, 8'd0, 5'd0,  1'b0, 5'd1,  1'b1, 1'b1};
    v[14] = '{8'd4, 1'b1, 8'd2, 5'd27, 1'b0, 5'd0,  1'b1, 1'b0};
    v[15] = '{8'd2, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[16] = '{8'd4, 1'b1, 8'd2, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    v[17] = '{8'd4, 1'b0, 8'd0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      ibeat = v[i].ib; wr_en = v[i].we; wr_addr = v[i].wa; wr_note = v[i].wn; mute = v[i].mu;
      tick();
      chk($sformatf("vec%0d_note", i), note_cur, v[i].en);
      chk($sformatf("vec%0d_tick", i), beat_tick, v[i].et);
      chk($sformatf("vec%0d_valid", i), note_valid, v[i].ev);
    end
    wr_en = 0; mute = 0;

    // score is now {10, 22, 0, 1}; step through beats 0..3
    for (int b = 0; b < 4; b++) begin
      ibeat = 8'(b);
      tick();
      e = 1;
      chk($sformatf("seq%0d_tick", b), beat_tick, 1);
      tick(); e++;
      chk($sformatf("seq%0d_tick_off", b), beat_tick, 0);
      if (hps[b] > 0) begin
        wait_level(1'b1, n); e += n;
        chk($sformatf("seq%0d_first_rise", b), n + 1, hps[b]);
        wait_level(1'b0, n); e += n;
        chk($sformatf("seq%0d_high", b), n, hps[b]);
        wait_level(1'b1, n); e += n;
        chk($sformatf("seq%0d_low", b), n, hps[b]);
      end else begin
        highs = 0;
        repeat (500) begin tick(); e++; highs += int'(audio_out); end
        chk("rest_audio_highs", highs, 0);
        chk("rest_valid", note_valid, 0);
      end
      repeat (2000 - e) tick();
    end

    // mute over part of an A4 tone; phase must continue underneath
    ibeat = 8'd0;
    tick();
    errs = 0;
    for (int t = 1; t <= 780; t++) begin
      mute = (t >= 111 && t <= 311);
      tick();
      exp = mute ? 0 : (t / 110) % 2;
      if (audio_out !== exp[0]) errs++;
      if (t == 150) chk("mute_valid", note_valid, 0);
      if (t == 400) chk("unmute_valid", note_valid, 1);
    end
    chk("mute_phase_errs", errs, 0);
    chk("pre_reset_audio", audio_out, 1);

    rst = 1;
    tick();
    chk("midrst_audio", audio_out, 0);
    chk("midrst_note", note_cur, 0);
    chk("midrst_valid", note_valid, 0);
    rst = 0;
    tick();
    chk("postrst_tick", beat_tick, 1);
    chk("postrst_note", note_cur, 0);
    highs = 0;
    repeat (300) begin tick(); highs += int'(audio_out); end
    chk("postrst_silent", highs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
